// File: rtl/jtag_debug_sys_instr_trace_fifo_if.sv
// ----------------------------------------------------------------------------
// jtag_debug_sys_instr_trace_fifo_if
// Purpose : bundles the core-side capture inputs, the host-side pop/clear
//           controls and the trace FIFO status outputs.
// Signals : capture_en, instr_valid, instr[31:0], pop_level, clear  (to FIFO)
//           trace_out[10:0], count[ADDR_W:0], overflow            (from FIFO)
// Modports: slave  - the trace FIFO itself
//           master - whatever drives the core/host side (core + PIO, or a bench)
// ----------------------------------------------------------------------------
interface jtag_debug_sys_instr_trace_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              capture_en;
    logic              instr_valid;
    logic [31:0]       instr;
    logic              pop_level;
    logic              clear;
    logic [10:0]       trace_out;
    logic [ADDR_W:0]   count;
    logic              overflow;

    modport slave (
        input  capture_en,
        input  instr_valid,
        input  instr,
        input  pop_level,
        input  clear,
        output trace_out,
        output count,
        output overflow
    );

    modport master (
        output capture_en,
        output instr_valid,
        output instr,
        output pop_level,
        output clear,
        input  trace_out,
        input  count,
        input  overflow
    );
endinterface

// File: rtl/jtag_debug_sys_instr_trace_fifo.sv
// ----------------------------------------------------------------------------
// jtag_debug_sys_instr_trace_fifo
// Purpose : compresses each issued 32-bit instruction to an 11-bit trace word
//           {gap, funct3, opcode} and queues it for a JTAG debug host that
//           reads the head through a PIO and advances the queue by toggling
//           pop_level.
// Ports   : clk    - system clock, rising edge
//           reset  - synchronous, active-high
//           bus    - slave modport: capture_en, instr_valid, instr, pop_level,
//                    clear in; trace_out, count, overflow out (all registered)
// ----------------------------------------------------------------------------
module jtag_debug_sys_instr_trace_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic clk,
    input  logic reset,
    jtag_debug_sys_instr_trace_fifo_if.slave bus
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [10:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic [10:0]       trace_q;
    logic              overflow_q;
    logic              gap_pend;
    logic              pop_d;

    logic              push_req;
    logic              pop_pulse;
    logic              full;
    logic              empty;
    logic              do_push;
    logic              do_pop;
    logic              drop;
    logic [10:0]       word;

    // Only opcode, funct3 and the length bits feed the trace word.
    logic              unused_instr_bits;
    assign unused_instr_bits = ^{bus.instr[31:15], bus.instr[11:7]};

    always_comb begin
        push_req  = bus.instr_valid & bus.capture_en & (bus.instr[1:0] == 2'b11);
        pop_pulse = bus.pop_level & ~pop_d;
        full      = (count_q == FULL_CNT);
        empty     = (count_q == '0);
        // A pop while empty is simply lost; a pop while full makes room for
        // a same-edge push.
        do_pop    = pop_pulse & ~empty;
        do_push   = push_req & (~full | pop_pulse);
        drop      = push_req & full & ~pop_pulse;
        word      = {gap_pend, bus.instr[14:12], bus.instr[6:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            trace_q    <= '0;
            overflow_q <= 1'b0;
            gap_pend   <= 1'b0;
            // Starting high means a level already high at release is not an edge.
            pop_d      <= 1'b1;
        end else begin
            pop_d <= bus.pop_level;
            if (bus.clear) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count_q    <= '0;
                trace_q    <= '0;
                overflow_q <= 1'b0;
                gap_pend   <= 1'b0;
            end else begin
                // Head is sampled from the registered pointer/count, giving the
                // one-cycle lag of trace_out behind count.
                trace_q <= empty ? 11'h000 : mem[rd_ptr];
                if (do_push) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    gap_pend <= 1'b0;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (drop) begin
                    overflow_q <= 1'b1;
                    gap_pend   <= 1'b1;
                end
                case ({do_push, do_pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !bus.clear && do_push) begin
            mem[wr_ptr] <= word;
        end
    end

    assign bus.trace_out = trace_q;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;

endmodule
